vga_sprite_sched: RTL

- Shares the on-screen sprite layer between up to N_SPR game-logic requesters and produces the pixel colour consumed by the VGA timing controller.
- Requesters write sprite descriptors (position, size, colour, enable) through a round-robin req/ack arbiter into a shadow bank.
- The shadow bank is copied to the active bank once per frame, at the start of vertical sync, so the image never tears.
- The pixel path is combinational from the controller's pixel coordinates to vga_data, with zero latency. The controller samples vga_data in the same cycle it presents the coordinates.

---
 rtl/vga_sprite_sched_if.sv | 23 ++
 rtl/vga_sprite_sched.sv | 136 +++++++++++++
 2 files changed

// File: rtl/vga_sprite_sched_if.sv
// Sprite descriptor write bus: per-requester req/ack handshake plus packed descriptor fields.
interface vga_sprite_sched_if #(
   parameter int unsigned N_SPR = 4
) ();
   logic [N_SPR-1:0]    req;
   logic [N_SPR*10-1:0] wr_x;
   logic [N_SPR*10-1:0] wr_y;
   logic [N_SPR*8-1:0]  wr_w;
   logic [N_SPR*8-1:0]  wr_h;
   logic [N_SPR*24-1:0] wr_rgb;
   logic [N_SPR-1:0]    wr_en;
   logic [N_SPR-1:0]    ack;

   modport master (
      output req, wr_x, wr_y, wr_w, wr_h, wr_rgb, wr_en,
      input  ack
   );

   modport slave (
      input  req, wr_x, wr_y, wr_w, wr_h, wr_rgb, wr_en,
      output ack
   );
endinterface

// File: rtl/vga_sprite_sched.sv
// Round-robin sprite descriptor writer with a shadow bank copied to the active bank at vsync,
// and a zero-latency combinational pixel colour path.
module vga_sprite_sched #(
   parameter int unsigned  N_SPR    = 4,
   parameter logic [23:0]  BG_COLOR = 24'h000000
) (
   input  logic                  clk_40mhz,
   input  logic                  rst_n,
   vga_sprite_sched_if.slave     bus,
   input  logic [9:0]            vga_xide,
   input  logic [9:0]            vga_yide,
   input  logic                  vga_vs,
   output logic [23:0]           vga_data,
   output logic                  frame_tick
);

   localparam int unsigned PTR_W = (N_SPR > 1) ? $clog2(N_SPR) : 1;

   typedef enum logic {ARB, SWAP} state_t;

   state_t            r_state, w_state_nxt;
   logic              r_vs_q;
   logic              w_swap_req;
   logic [PTR_W-1:0]  r_ptr;
   logic [PTR_W-1:0]  w_cand;
   logic              w_grant_vld;
   logic [PTR_W-1:0]  w_grant_idx;
   logic [N_SPR-1:0]  w_ack;
   logic [N_SPR-1:0]  w_hit;
   logic              w_pix_found;

   logic [9:0]  r_sh_x   [N_SPR];
   logic [9:0]  r_sh_y   [N_SPR];
   logic [7:0]  r_sh_w   [N_SPR];
   logic [7:0]  r_sh_h   [N_SPR];
   logic [23:0] r_sh_rgb [N_SPR];
   logic        r_sh_en  [N_SPR];
   logic [9:0]  r_ac_x   [N_SPR];
   logic [9:0]  r_ac_y   [N_SPR];
   logic [7:0]  r_ac_w   [N_SPR];
   logic [7:0]  r_ac_h   [N_SPR];
   logic [23:0] r_ac_rgb [N_SPR];
   logic        r_ac_en  [N_SPR];

   assign w_swap_req = r_vs_q & ~vga_vs;

   always_ff @(posedge clk_40mhz or negedge rst_n) begin
      if (!rst_n) r_state <= ARB;
      else        r_state <= w_state_nxt;
   end

   // Grant search walks from r_ptr upward, wrapping modulo N_SPR; first set request wins.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      w_cand      = '0;
      w_ack       = '0;
      unique case (r_state)
         ARB: begin
            if (w_swap_req) begin
               w_state_nxt = SWAP;
            end else begin
               for (int unsigned k = 0; k < N_SPR; k++) begin
                  w_cand = PTR_W'((32'(r_ptr) + k) % N_SPR);
                  if (!w_grant_vld && bus.req[w_cand]) begin
                     w_grant_vld = 1'b1;
                     w_grant_idx = w_cand;
                  end
               end
            end
         end
         SWAP:    w_state_nxt = ARB;
         default: w_state_nxt = ARB;
      endcase
      if (w_grant_vld) w_ack[w_grant_idx] = 1'b1;
   end

   // Ack is a same-cycle pulse; gating with rst_n keeps a grant from escaping during reset.
   assign bus.ack = rst_n ? w_ack : '0;

   always_ff @(posedge clk_40mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_q     <= 1'b1;
         r_ptr      <= '0;
         frame_tick <= 1'b0;
         for (int unsigned i = 0; i < N_SPR; i++) begin
            r_sh_x[i] <= '0; r_sh_y[i] <= '0; r_sh_w[i] <= '0; r_sh_h[i] <= '0;
            r_sh_rgb[i] <= '0; r_sh_en[i] <= 1'b0;
            r_ac_x[i] <= '0; r_ac_y[i] <= '0; r_ac_w[i] <= '0; r_ac_h[i] <= '0;
            r_ac_rgb[i] <= '0; r_ac_en[i] <= 1'b0;
         end
      end else begin
         r_vs_q     <= vga_vs;
         frame_tick <= (r_state == SWAP);
         if (w_grant_vld) r_ptr <= PTR_W'((32'(w_grant_idx) + 1) % N_SPR);
         for (int unsigned i = 0; i < N_SPR; i++) begin
            if (w_grant_vld && (w_grant_idx == PTR_W'(i))) begin
               r_sh_x[i]   <= bus.wr_x[i*10 +: 10];
               r_sh_y[i]   <= bus.wr_y[i*10 +: 10];
               r_sh_w[i]   <= bus.wr_w[i*8 +: 8];
               r_sh_h[i]   <= bus.wr_h[i*8 +: 8];
               r_sh_rgb[i] <= bus.wr_rgb[i*24 +: 24];
               r_sh_en[i]  <= bus.wr_en[i];
            end
            if (r_state == SWAP) begin
               r_ac_x[i]   <= r_sh_x[i];
               r_ac_y[i]   <= r_sh_y[i];
               r_ac_w[i]   <= r_sh_w[i];
               r_ac_h[i]   <= r_sh_h[i];
               r_ac_rgb[i] <= r_sh_rgb[i];
               r_ac_en[i]  <= r_sh_en[i];
            end
         end
      end
   end

   // 11-bit right/bottom edges so sprites past the screen edge clip instead of wrapping.
   always_comb begin
      w_hit       = '0;
      w_pix_found = 1'b0;
      vga_data    = BG_COLOR;
      for (int unsigned i = 0; i < N_SPR; i++) begin
         w_hit[i] = r_ac_en[i]
                  && (vga_xide >= r_ac_x[i])
                  && ({1'b0, vga_xide} < ({1'b0, r_ac_x[i]} + {3'b000, r_ac_w[i]}))
                  && (vga_yide >= r_ac_y[i])
                  && ({1'b0, vga_yide} < ({1'b0, r_ac_y[i]} + {3'b000, r_ac_h[i]}));
         if (!w_pix_found && w_hit[i]) begin
            w_pix_found = 1'b1;
            vga_data    = r_ac_rgb[i];
         end
      end
   end

endmodule
